// File: rtl/random_checker.sv
`default_nettype none
// ============================================================================
// Module   : random_checker
// Purpose  : Self-synchronizing receive-side checker for the LFSR serial
//            pseudo-random stream; acquires lock, flags and counts bit errors.
// Revision : 1.0 - initial release
// ============================================================================
module random_checker #(
  parameter int LOCK_THRESH = 16,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       tap,
  input  logic             en,
  input  logic             din,
  input  logic             clear,
  output logic             lock,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt
);

  localparam logic [7:0]       c_LOCK_THRESH = 8'(LOCK_THRESH);
  localparam logic [7:0]       c_LOSS_THRESH = 8'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] c_ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_HUNT = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t           r_state;
  logic [2:0]       r_fill;
  logic [7:0]       r_win;
  logic [7:0]       r_good;
  logic [7:0]       r_miss;
  logic             r_lock;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_chk_cnt;

  logic       w_pred;
  logic       w_miss;
  logic       w_zero;
  logic [7:0] w_good_inc;
  logic [7:0] w_miss_inc;

  // Prediction uses the window before this bit is shifted in.
  assign w_pred     = ^(tap & r_win);
  assign w_miss     = (din != w_pred);
  assign w_zero     = (r_win == 8'h00);
  assign w_good_inc = r_good + 8'd1;
  assign w_miss_inc = r_miss + 8'd1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state   <= S_FILL;
      r_fill    <= 3'd0;
      r_win     <= 8'h00;
      r_good    <= 8'd0;
      r_miss    <= 8'd0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (en) begin
        // The window shifts on every bit, good or bad, so it resynchronizes.
        r_win <= {din, r_win[7:1]};
        case (r_state)
          S_FILL: begin
            r_fill <= r_fill + 3'd1;
            if (r_fill == 3'd7) begin
              r_state <= S_HUNT;
            end
          end
          S_HUNT: begin
            // A zero window would predict zeros forever; never credit it.
            if (!w_miss && !w_zero) begin
              if (w_good_inc == c_LOCK_THRESH) begin
                r_state <= S_LOCK;
                r_lock  <= 1'b1;
                r_good  <= 8'd0;
              end else begin
                r_good <= w_good_inc;
              end
            end else begin
              r_good <= 8'd0;
            end
          end
          S_LOCK: begin
            if (r_chk_cnt != '1) begin
              r_chk_cnt <= r_chk_cnt + c_CNT_ONE;
            end
            if (w_miss || w_zero) begin
              r_err <= 1'b1;
              if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + c_ERR_ONE;
              end
              if (w_miss_inc == c_LOSS_THRESH) begin
                r_state <= S_HUNT;
                r_lock  <= 1'b0;
                r_miss  <= 8'd0;
                r_good  <= 8'd0;
              end else begin
                r_miss <= w_miss_inc;
              end
            end else begin
              r_miss <= 8'd0;
            end
          end
          default: begin
            r_state <= S_FILL;
          end
        endcase
      end
    end
  end

  assign lock    = r_lock;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;
  assign chk_cnt = r_chk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_random_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_checker
// Purpose  : Randomized self-checking bench for random_checker against a
//            bit-history reference model; second instance exercises saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_checker;

  logic        clk;
  logic        rst;
  logic [7:0]  tap;
  logic        en;
  logic        din;
  logic        clear;
  logic        lock1, err1, lock2, err2;
  logic [15:0] errc1;
  logic [31:0] chk1;
  logic [1:0]  errc2;
  logic [3:0]  chk2;

  random_checker #(.LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .tap(tap), .en(en), .din(din), .clear(clear),
    .lock(lock1), .err(err1), .err_cnt(errc1), .chk_cnt(chk1)
  );

  random_checker #(.LOCK_THRESH(16), .LOSS_THRESH(4), .ERR_W(2), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .tap(tap), .en(en), .din(din), .clear(clear),
    .lock(lock2), .err(err2), .err_cnt(errc2), .chk_cnt(chk2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: history of received bits, phase as plain integers.
  int     m_phase;   // 0 = filling, 1 = hunting, 2 = locked
  int     m_filled, m_good, m_mrun;
  bit     m_err;
  longint m_errc, m_chk;
  bit     hist[$];
  logic [7:0] g;     // transmit-side generator state

  logic [57:0] act;
  assign act = {lock1, err1, errc1, chk1, lock2, err2, errc2, chk2};

  function automatic logic [57:0] exp_vec();
    longint e1, c1, e2, c2;
    bit     l;
    e1 = (m_errc > 65535) ? 65535 : m_errc;
    c1 = (m_chk > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_chk;
    e2 = (m_errc > 3) ? 3 : m_errc;
    c2 = (m_chk > 15) ? 15 : m_chk;
    l  = (m_phase == 2);
    return {l, m_err, 16'(e1), 32'(c1), l, m_err, 2'(e2), 4'(c2)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_filled = 0; m_good = 0; m_mrun = 0;
    m_err = 0; m_errc = 0; m_chk = 0;
    hist.delete();
    repeat (8) hist.push_back(1'b0);
  endtask

  task automatic model_update(input bit rc, input bit e, input bit d);
    bit p, z, bad;
    if (rc) begin
      model_reset();
      return;
    end
    m_err = 0;
    if (!e) return;
    p = 0; z = 1;
    for (int i = 0; i < 8; i++) begin
      if (tap[i]) p ^= hist[i];
      if (hist[i]) z = 0;
    end
    bad = (d != p) || z;
    if (m_phase == 0) begin
      m_filled++;
      if (m_filled == 8) m_phase = 1;
    end else if (m_phase == 1) begin
      m_good = bad ? 0 : m_good + 1;
      if (m_good == 16) begin m_phase = 2; m_good = 0; end
    end else begin
      m_chk++;
      if (bad) begin
        m_err = 1; m_errc++; m_mrun++;
      end else begin
        m_mrun = 0;
      end
      if (m_mrun == 4) begin m_phase = 1; m_mrun = 0; m_good = 0; end
    end
    hist.push_back(d);
    void'(hist.pop_front());
  endtask

  function automatic bit gen_next();
    bit o;
    o = g[0];
    g = {^(g & tap), g[7:1]};
    return o;
  endfunction

  task automatic step(input bit r, input bit e, input bit d, input bit c);
    @(negedge clk);
    rst = r; en = e; din = d; clear = c;
    @(posedge clk);
    #1;
    model_update(r | c, e, d);
  endtask

  // Seed with a nonzero upper part so the stream never collapses to zeros.
  task automatic new_stream(input logic [7:0] t);
    tap = t;
    g   = 8'($urandom_range(8, 255));
  endtask

  // Flips one stream bit (chosen where the true bit is 0) and records the
  // err pattern of both instances over the following 12 bits.
  task automatic flip_once(output logic [11:0] m1, output logic [11:0] m2);
    int n = 0;
    while (g[0] == 1'b1 && n < 40) begin
      step(0, 1, gen_next(), 0);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      bit b = gen_next();
      if (i == 0) b = ~b;
      step(0, 1, b, 0);
      m1[i] = err1;
      m2[i] = err2;
    end
  endtask

  task automatic test_reset();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      n_vec++;
      if (act !== 58'd0) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%h want=0", i, act);
      end
    end
  endtask

  task automatic test_clean_lock();
    new_stream(8'hB8);
    step(0, 1, 0, 1);
    for (int v = 1; v <= 224; v++) begin
      step(0, 1, gen_next(), 0);
      n_vec++;
      if (act !== exp_vec() || lock1 !== (v >= 24) || err1 !== 1'b0) begin
        n_bad++;
        $display("FAIL clean_lock bit=%0d got=%h want=%h lock_want=%0d", v, act, exp_vec(), v >= 24);
      end
    end
    n_vec++;
    if (chk1 !== 32'd200 || errc1 !== 16'd0 || chk2 !== 4'd15) begin
      n_bad++;
      $display("FAIL clean_counts chk=%0d errc=%0d chk_sat=%0d want 200/0/15", chk1, errc1, chk2);
    end
  endtask

  task automatic test_bit_flip();
    logic [11:0] m1, m2;
    logic [15:0] base;
    base = errc1;
    flip_once(m1, m2);
    n_vec++;
    if (m1 !== 12'h03B || errc1 !== base + 16'd5 || lock1 !== 1'b1) begin
      n_bad++;
      $display("FAIL bit_flip pattern=%h errc=%0d lock=%0d want 03b/%0d/1", m1, errc1, lock1, base + 16'd5);
    end
    n_vec++;
    if (act !== exp_vec()) begin
      n_bad++;
      $display("FAIL bit_flip_model got=%h want=%h", act, exp_vec());
    end
  endtask

  task automatic test_saturation();
    logic [11:0] m1, m2;
    for (int k = 0; k < 2; k++) begin
      flip_once(m1, m2);
      n_vec++;
      if (m2 !== 12'h03B || errc2 !== 2'd3 || act !== exp_vec()) begin
        n_bad++;
        $display("FAIL saturation flip=%0d pattern=%h errc_sat=%0d want 03b/3 got=%h want=%h",
                 k, m2, errc2, act, exp_vec());
      end
    end
  endtask

  task automatic test_stuck_one();
    logic [15:0] base;
    int          run;
    int          n;
    bit          fell;
    base = errc1; run = 0; fell = 0; n = 0;
    while (!fell && n < 30) begin
      void'(gen_next());
      step(0, 1, 1, 0);
      n++;
      run = err1 ? run + 1 : 0;
      fell = (lock1 == 1'b0);
      n_vec++;
      if (act !== exp_vec()) begin
        n_bad++;
        $display("FAIL stuck step=%0d got=%h want=%h", n, act, exp_vec());
      end
    end
    n_vec++;
    if (!fell || run < 4 || errc1 <= base) begin
      n_bad++;
      $display("FAIL stuck_loss fell=%0d err_run=%0d errc=%0d base=%0d", fell, run, errc1, base);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0);
      n_vec++;
      if (lock1 !== 1'b0 || err1 !== 1'b0 || act !== exp_vec()) begin
        n_bad++;
        $display("FAIL stuck_hunt step=%0d got=%h want=%h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_dead_line();
    step(0, 1, 0, 1);
    for (int i = 0; i < 100; i++) begin
      step(0, 1, 0, 0);
      n_vec++;
      if (lock1 !== 1'b0 || err1 !== 1'b0 || act !== exp_vec()) begin
        n_bad++;
        $display("FAIL dead_line step=%0d got=%h want=%h", i, act, exp_vec());
      end
    end
  endtask

  task automatic test_sparse_clear();
    int v = 0;
    new_stream(8'hB8);
    step(0, 1, 0, 1);
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) begin
        step(0, 1, gen_next(), 0);
        v++;
      end else begin
        step(0, 0, $urandom_range(0, 1), 0);
      end
      n_vec++;
      if (lock1 !== (v >= 24) || act !== exp_vec()) begin
        n_bad++;
        $display("FAIL sparse_lock cyc=%0d valid=%0d got=%h want=%h", i, v, act, exp_vec());
      end
    end
    step(0, 1, gen_next(), 1);
    n_vec++;
    if (act !== 58'd0) begin
      n_bad++;
      $display("FAIL clear_with_en got=%h want=0", act);
    end
    v = 0;
    for (int i = 0; i < 56; i++) begin
      if (i % 2 == 0) begin
        step(0, 1, gen_next(), 0);
        v++;
      end else begin
        step(0, 0, $urandom_range(0, 1), 0);
      end
      n_vec++;
      if (lock1 !== (v >= 24) || act !== exp_vec()) begin
        n_bad++;
        $display("FAIL relock cyc=%0d valid=%0d got=%h want=%h", i, v, act, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      new_stream(8'($urandom_range(1, 255)));
      step(0, 1, 0, 1);
      for (int i = 0; i < 300; i++) begin
        bit e, b;
        e = ($urandom_range(0, 9) < 7);
        b = e ? gen_next() : 1'b0;
        if ($urandom_range(0, 49) == 0) b = ~b;
        step(0, e, b, 0);
        n_vec++;
        if (act !== exp_vec()) begin
          n_bad++;
          $display("FAIL random tap=%h cyc=%0d got=%h want=%h", tap, i, act, exp_vec());
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; clear = 1'b0; tap = 8'hB8; g = 8'h01;
    test_reset();
    test_clean_lock();
    test_bit_flip();
    test_saturation();
    test_stuck_one();
    test_dead_line();
    test_sparse_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
